csr_decoder: RTL and testbench



---
 rtl/csr_pkg.sv | 26 ++
 rtl/csr_pos_check.sv | 19 +
 rtl/csr_decoder.sv | 115 +++++++++++
 tb/tb_csr_decoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants, FSM encoding and raster-position helper for the CSR decoder.
package csr_pkg;
    localparam int COL_LENGTH         = 8;
    localparam int WORD_LENGTH        = 8;
    localparam int DOUBLE_WORD_LENGTH = 16;
    localparam int IMAGE_SIZE         = 28;

    localparam logic [COL_LENGTH-1:0]         SIZE_IDX     = COL_LENGTH'(IMAGE_SIZE);
    localparam logic [DOUBLE_WORD_LENGTH-1:0] SIZE_WIDE    = DOUBLE_WORD_LENGTH'(IMAGE_SIZE);
    localparam logic [DOUBLE_WORD_LENGTH-1:0] IMAGE_PIXELS = DOUBLE_WORD_LENGTH'(IMAGE_SIZE * IMAGE_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } state_t;

    // Raster position row*size+col, kept in counter width so it compares directly with idx.
    function automatic logic [DOUBLE_WORD_LENGTH-1:0] pos(
        input logic [COL_LENGTH-1:0] row,
        input logic [COL_LENGTH-1:0] col
    );
        return DOUBLE_WORD_LENGTH'(row) * SIZE_WIDE + DOUBLE_WORD_LENGTH'(col);
    endfunction
endpackage

// File: rtl/csr_pos_check.sv
// Compares an entry's raster position against the current pixel index.
module csr_pos_check
    import csr_pkg::*;
(
    input  logic [COL_LENGTH-1:0]         row,
    input  logic [COL_LENGTH-1:0]         col,
    input  logic [DOUBLE_WORD_LENGTH-1:0] idx,
    output logic                          pos_eq,
    output logic                          pos_gt,
    output logic                          bad
);
    logic [DOUBLE_WORD_LENGTH-1:0] p;

    assign p      = pos(row, col);
    assign pos_eq = (p == idx);
    assign pos_gt = (p > idx);
    // Out-of-frame coordinates or a position already passed both mean a malformed stream.
    assign bad    = (col >= SIZE_IDX) || (row >= SIZE_IDX) || (p < idx);
endmodule

// File: rtl/csr_decoder.sv
// Rebuilds a dense raster pixel stream from CSR (value, col, row) entries.
module csr_decoder
    import csr_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DOUBLE_WORD_LENGTH-1:0] nnz,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_LENGTH-1:0]        in_value,
    input  logic [COL_LENGTH-1:0]         in_col,
    input  logic [COL_LENGTH-1:0]         in_row,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_LENGTH-1:0]        data_out,
    output logic                          out_last,
    output logic                          done,
    output logic                          error
);
    state_t                        state;
    logic [DOUBLE_WORD_LENGTH-1:0] idx;
    logic [DOUBLE_WORD_LENGTH-1:0] cons;
    logic [DOUBLE_WORD_LENGTH-1:0] nnz_q;
    logic                          pos_eq;
    logic                          pos_gt;
    logic                          bad;
    logic                          load;
    logic                          more;
    logic                          need;

    csr_pos_check u_pos (
        .row    (in_row),
        .col    (in_col),
        .idx    (idx),
        .pos_eq (pos_eq),
        .pos_gt (pos_gt),
        .bad    (bad)
    );

    assign load = !out_valid || out_ready;
    // idx reaches N once pixel N-1 is loaded, which blocks any further loads.
    assign more = idx < IMAGE_PIXELS;
    assign need = (state == RUN) && load && more && (cons < nnz_q);
    assign in_ready = need && in_valid && !bad && pos_eq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            cons      <= '0;
            nnz_q     <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (start) begin
                        nnz_q <= nnz;
                        idx   <= '0;
                        cons  <= '0;
                        if (nnz > IMAGE_PIXELS) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (out_valid && out_ready && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (cons != nnz_q) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end else if (load && more) begin
                        if (cons == nnz_q || (in_valid && !bad)) begin
                            data_out  <= (cons != nnz_q && pos_eq) ? in_value : '0;
                            out_valid <= 1'b1;
                            out_last  <= (idx == IMAGE_PIXELS - 1'b1);
                            idx       <= idx + 1'b1;
                            if (in_ready) cons <= cons + 1'b1;
                        end else if (in_valid) begin
                            state     <= ERR;
                            error     <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    error     <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csr_decoder.sv
// Randomized frame bench for csr_decoder against a dense-array reference model.
module tb_csr_decoder;
    localparam int N  = 784;
    localparam int SZ = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] nnz = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_value = '0;
    logic [7:0]  in_col = '0;
    logic [7:0]  in_row = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  data_out;
    logic        out_last;
    logic        done;
    logic        error;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_pix [N];
    logic [7:0] q_val [$];
    logic [7:0] q_col [$];
    logic [7:0] q_row [$];

    csr_decoder dut (
        .clk(clk), .rst(rst), .start(start), .nnz(nnz),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .in_col(in_col), .in_row(in_row), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .out_last(out_last),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) exp_pix[i] = 8'd0;
        q_val.delete(); q_col.delete(); q_row.delete();
    endtask

    task automatic add_entry(input int v, input int c, input int r);
        q_val.push_back(8'(v)); q_col.push_back(8'(c)); q_row.push_back(8'(r));
        if (c < SZ && r < SZ) exp_pix[r * SZ + c] = 8'(v);
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        nnz = 16'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives the entry queue with out_ready=1 for a fixed cycle count; counts accepted beats.
    task automatic pump(input int cycles, output int beats);
        beats = 0;
        for (int c = 0; c < cycles; c++) begin
            out_ready = 1'b1;
            in_valid  = q_val.size() > 0;
            if (q_val.size() > 0) begin
                in_value = q_val[0]; in_col = q_col[0]; in_row = q_row[0];
            end
            #1;
            if (in_valid && in_ready) begin
                void'(q_val.pop_front()); void'(q_col.pop_front()); void'(q_row.pop_front());
            end
            if (out_valid && out_ready) beats++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Runs one frame through the DUT checking every beat; abort_at>=0 stops after that many beats.
    task automatic run_frame(input string name, input int n, input bit rnd_ready,
                             input bit gaps, input int abort_at);
        int beats = 0;
        int cyc = 0;
        bit prev_hold = 1'b0;
        logic [7:0] prev_data = '0;
        logic prev_last = 1'b0;
        pulse_start(n);
        while (beats < N && cyc < 6000) begin
            cyc++;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (q_val.size() > 0) begin
                in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_value = q_val[0]; in_col = q_col[0]; in_row = q_row[0];
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_value = 8'($urandom); in_col = 8'($urandom_range(0, SZ - 1));
                in_row = 8'($urandom_range(0, SZ - 1));
            end
            #1;
            if (prev_hold) begin
                vectors++;
                if (out_valid !== 1'b1 || data_out !== prev_data || out_last !== prev_last) begin
                    miscompares++;
                    $display("FAIL %s hold beat %0d: valid=%b data=%0d last=%b, required 1/%0d/%b",
                             name, beats, out_valid, data_out, out_last, prev_data, prev_last);
                end
            end
            if (in_valid && in_ready) begin
                if (q_val.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL %s extra read at beat %0d: in_ready=1, required 0", name, beats);
                end else begin
                    void'(q_val.pop_front()); void'(q_col.pop_front()); void'(q_row.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (data_out !== exp_pix[beats] || out_last !== (beats == N - 1)) begin
                    miscompares++;
                    $display("FAIL %s beat %0d: data=%0d last=%b, required %0d/%b",
                             name, beats, data_out, out_last, exp_pix[beats], beats == N - 1);
                end
                beats++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = data_out;
            prev_last = out_last;
            @(negedge clk);
            if (abort_at >= 0 && beats >= abort_at) break;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (abort_at >= 0) return;
        vectors++;
        if (beats != N) begin
            miscompares++;
            $display("FAIL %s timeout: beats=%0d, required %0d", name, beats, N);
            return;
        end
        #1;
        vectors++;
        if (done !== 1'b0 || q_val.size() != 0) begin
            miscompares++;
            $display("FAIL %s early done: done=%b left=%0d, required 0/0", name, done, q_val.size());
        end
        @(negedge clk); #1;
        vectors++;
        if (done !== 1'b1 || error !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done pulse: done=%b error=%b valid=%b, required 1/0/0",
                     name, done, error, out_valid);
        end
        @(negedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done width: done=%b, required 0", name, done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || data_out !== 8'd0 ||
            out_last !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: valid=%b rdy=%b data=%0d last=%b done=%b err=%b, required all 0",
                     out_valid, in_ready, data_out, out_last, done, error);
        end
    endtask

    task automatic test_zero_frame();
        clear_model();
        run_frame("nnz0", 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_three_entries(input bit stress);
        clear_model();
        add_entry(5, 0, 0); add_entry(9, 27, 0); add_entry(7, 27, 27);
        run_frame(stress ? "three_bp" : "three", 3, stress, stress, -1);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            int cnt = 0;
            clear_model();
            for (int p = 0; p < N; p++) begin
                if (f == 2 || $urandom_range(0, 7) == 0) begin
                    add_entry($urandom_range(1, 255), p % SZ, p / SZ);
                    cnt++;
                end
            end
            run_frame(f == 2 ? "full" : "random", cnt, f != 0, f == 1, -1);
        end
    endtask

    task automatic test_out_of_order();
        int beats;
        clear_model();
        add_entry(1, 3, 0); add_entry(2, 1, 0);
        pulse_start(2);
        pump(20, beats);
        #1;
        vectors++;
        if (error !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || q_val.size() != 1) begin
            miscompares++;
            $display("FAIL order: err=%b valid=%b rdy=%b left=%0d, required 1/0/0/1",
                     error, out_valid, in_ready, q_val.size());
        end
        pulse_start(0);
        pump(5, beats);
        #1;
        vectors++;
        if (error !== 1'b1 || beats != 0) begin
            miscompares++;
            $display("FAIL order sticky: err=%b beats=%0d, required 1/0", error, beats);
        end
        do_reset();
        #1;
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL order reset: err=%b, required 0", error);
        end
    endtask

    task automatic test_stall_and_bad();
        int beats;
        clear_model();
        add_entry(6, 2, 0);
        pulse_start(2);
        pump(30, beats);
        #1;
        vectors++;
        if (beats != 3 || out_valid !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL stall: beats=%0d valid=%b err=%b, required 3/0/0", beats, out_valid, error);
        end
        do_reset();
        clear_model();
        add_entry(4, 30, 0);
        pulse_start(1);
        pump(10, beats);
        #1;
        vectors++;
        if (error !== 1'b1 || beats != 0) begin
            miscompares++;
            $display("FAIL bad col: err=%b beats=%0d, required 1/0", error, beats);
        end
        do_reset();
        pulse_start(N + 1);
        #1;
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("FAIL nnz over: err=%b, required 1", error);
        end
        do_reset();
    endtask

    task automatic test_midframe_reset();
        clear_model();
        run_frame("abort", 0, 1'b0, 1'b0, 100);
        do_reset();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL abort reset: valid=%b last=%b, required 0/0", out_valid, out_last);
        end
        clear_model();
        add_entry(8, 0, 0);
        run_frame("after_abort", 1, 1'b0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_three_entries(1'b0);
        test_three_entries(1'b1);
        test_random_frames();
        test_out_of_order();
        test_stall_and_bad();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
